// File: rtl/sipo_lane_arbiter.sv
// sipo_lane_arbiter: one serial-to-parallel capture datapath shared round-robin among
// NUM_LANES serial requesters. Completed words leave over a valid/ready handshake,
// tagged with the lane index that produced them.
// Optional feature macro: SIPO_ARB_PARITY_EN (adds a trailing even-parity bit per word).
module sipo_lane_arbiter #(
    parameter int unsigned  SIZE      = 8,
    parameter int unsigned  SHIFT_DIR = 0,
    parameter int unsigned  NUM_LANES = 4,
    localparam int unsigned LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_LANES-1:0] i_req,
    input  logic [NUM_LANES-1:0] i_ser_in,
    output logic [NUM_LANES-1:0] o_grant,
    output logic                 o_bit_en,
    output logic                 o_busy,
    output logic [SIZE-1:0]      o_word_out,
    output logic [LANE_W-1:0]    o_word_lane,
    output logic                 o_word_valid,
    input  logic                 i_word_ready,
    output logic                 o_abort,
    output logic                 o_parity_err
);

`ifdef SIPO_ARB_PARITY_EN
    localparam int unsigned NBITS = SIZE + 1;
`else
    localparam int unsigned NBITS = SIZE;
`endif
    localparam int unsigned CNT_W = $clog2(SIZE + 1);

    typedef enum logic [1:0] {StIdle, StShift, StOut} state_t;

    state_t                r_state;
    logic [LANE_W-1:0]     r_ptr;       // last granted lane; also the active lane in SHIFT
    logic [CNT_W-1:0]      r_cnt;
    logic [SIZE-1:0]       r_shift;     // partial word, kept apart so word_out survives aborts
    logic [NUM_LANES-1:0]  r_grant;
    logic                  r_bit_en;
    logic                  r_busy;
    logic [SIZE-1:0]       r_word_out;
    logic [LANE_W-1:0]     r_word_lane;
    logic                  r_word_valid;
    logic                  r_abort;
`ifdef SIPO_ARB_PARITY_EN
    logic                  r_parity_err;
`endif

    logic [LANE_W-1:0]     w_sel;
    logic                  w_any_req;
    logic [CNT_W-1:0]      w_pos;
    logic [SIZE-1:0]       w_mask;
    logic [SIZE-1:0]       w_next_shift;
    logic                  w_bit;
    logic                  w_req_sel;
    logic                  w_last;

    // Round-robin search: first requesting lane strictly after the last granted one.
    always_comb begin
        logic [LANE_W-1:0] v_idx;
        v_idx     = '0;
        w_sel     = r_ptr;
        w_any_req = 1'b0;
        for (int unsigned i = 1; i <= NUM_LANES; i++) begin
            v_idx = LANE_W'((32'(r_ptr) + i) % NUM_LANES);
            if (!w_any_req && i_req[v_idx]) begin
                w_sel     = v_idx;
                w_any_req = 1'b1;
            end
        end
    end

    // Bit placement for the current sample; the parity slot (cnt == SIZE) yields an empty mask.
    always_comb begin
        w_bit        = i_ser_in[r_ptr];
        w_req_sel    = i_req[r_ptr];
        w_last       = (r_cnt == CNT_W'(NBITS - 1));
        w_pos        = (SHIFT_DIR != 0) ? (CNT_W'(SIZE - 1) - r_cnt) : r_cnt;
        w_mask       = (r_cnt < CNT_W'(SIZE)) ? (SIZE'(1) << w_pos) : '0;
        w_next_shift = w_bit ? (r_shift | w_mask) : (r_shift & ~w_mask);
    end

    // Arbitration / capture / hand-off state machine with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_ptr        <= LANE_W'(NUM_LANES - 1);
            r_cnt        <= '0;
            r_shift      <= '0;
            r_grant      <= '0;
            r_bit_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_word_out   <= '0;
            r_word_lane  <= '0;
            r_word_valid <= 1'b0;
            r_abort      <= 1'b0;
`ifdef SIPO_ARB_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_abort <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_grant  <= NUM_LANES'(1) << w_sel;
                        r_bit_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_ptr    <= w_sel;
                        r_cnt    <= '0;
                        r_shift  <= '0;
                        r_state  <= StShift;
                    end
                end
                StShift: begin
                    if (!w_req_sel) begin
                        // Requester withdrew: drop the partial word, keep ptr on this lane.
                        r_grant  <= '0;
                        r_bit_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_abort  <= 1'b1;
                        r_state  <= StIdle;
                    end else if (w_last) begin
`ifdef SIPO_ARB_PARITY_EN
                        // Final sample is the parity bit; data bits are already in r_shift.
                        r_word_out   <= r_shift;
                        r_parity_err <= (^r_shift) ^ w_bit;
`else
                        r_word_out   <= w_next_shift;
`endif
                        r_word_lane  <= r_ptr;
                        r_word_valid <= 1'b1;
                        r_grant      <= '0;
                        r_bit_en     <= 1'b0;
                        r_state      <= StOut;
                    end else begin
                        r_shift <= w_next_shift;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                StOut: begin
                    if (i_word_ready) begin
                        r_word_valid <= 1'b0;
`ifdef SIPO_ARB_PARITY_EN
                        r_parity_err <= 1'b0;
`endif
                        r_busy       <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_grant      = r_grant;
    assign o_bit_en     = r_bit_en;
    assign o_busy       = r_busy;
    assign o_word_out   = r_word_out;
    assign o_word_lane  = r_word_lane;
    assign o_word_valid = r_word_valid;
    assign o_abort      = r_abort;
`ifdef SIPO_ARB_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_lane_arbiter.sv
// tb_sipo_lane_arbiter: randomized lane traffic against a word-level reference model.
// The driver predicts each grant from the round-robin rule, serializes lane words and pushes
// the expected delivery into a queue; an independent monitor checks every presented word.
module tb_sipo_lane_arbiter;
    localparam int unsigned SIZE      = 8;
    localparam int unsigned SHIFT_DIR = 0;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = $clog2(NUM_LANES);
    localparam int          NL        = NUM_LANES;
`ifdef SIPO_ARB_PARITY_EN
    localparam int          NBITS     = SIZE + 1;
    localparam bit          PAR_EN    = 1'b1;
`else
    localparam int          NBITS     = SIZE;
    localparam bit          PAR_EN    = 1'b0;
`endif
    localparam int          NUM_XFERS = 60;

    logic                 clk = 1'b0;
    logic                 i_reset;
    logic [NUM_LANES-1:0] i_req;
    logic [NUM_LANES-1:0] i_ser_in;
    logic [NUM_LANES-1:0] o_grant;
    logic                 o_bit_en;
    logic                 o_busy;
    logic [SIZE-1:0]      o_word_out;
    logic [LANE_W-1:0]    o_word_lane;
    logic                 o_word_valid;
    logic                 i_word_ready;
    logic                 o_abort;
    logic                 o_parity_err;

    sipo_lane_arbiter #(
        .SIZE      (SIZE),
        .SHIFT_DIR (SHIFT_DIR),
        .NUM_LANES (NUM_LANES)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .i_ser_in     (i_ser_in),
        .o_grant      (o_grant),
        .o_bit_en     (o_bit_en),
        .o_busy       (o_busy),
        .o_word_out   (o_word_out),
        .o_word_lane  (o_word_lane),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_abort      (o_abort),
        .o_parity_err (o_parity_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic [SIZE-1:0]   word;
        logic              perr;
    } exp_t;

    exp_t                 exp_q[$];
    int                   n_checks = 0;
    int                   n_errors = 0;
    int                   exp_aborts = 0;
    int                   seen_aborts = 0;
    int                   model_ptr;
    logic [SIZE-1:0]      last_word;
    logic [SIZE-1:0]      lane_word [NUM_LANES];
    logic                 lane_perr [NUM_LANES];
    logic [NUM_LANES-1:0] req_s;

    always @(posedge clk) req_s <= i_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(o_grant), 32'd0);
        chk({tag, "_bit_en"}, 32'(o_bit_en), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_word_out"}, 32'(o_word_out), 32'd0);
        chk({tag, "_word_lane"}, 32'(o_word_lane), 32'd0);
        chk({tag, "_word_valid"}, 32'(o_word_valid), 32'd0);
        chk({tag, "_abort"}, 32'(o_abort), 32'd0);
        chk({tag, "_parity_err"}, 32'(o_parity_err), 32'd0);
    endtask

    // Reference arbitration rule: first requester after the last granted lane.
    function automatic int rr_pick(input int ptr, input logic [NUM_LANES-1:0] mask);
        for (int i = 1; i <= NL; i++) begin
            int idx = (ptr + i) % NL;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // k-th transmitted bit of a lane word; the extra slot is the (possibly corrupted) parity.
    function automatic logic stream_bit(input logic [SIZE-1:0] w, input logic inj, input int k);
        if (k >= int'(SIZE)) return (^w) ^ inj;
        if (SHIFT_DIR != 0) return w[int'(SIZE) - 1 - k];
        return w[k];
    endfunction

    task automatic load_lane(input int l);
        lane_word[l] = SIZE'($urandom);
        lane_perr[l] = PAR_EN && ($urandom_range(0, 1) == 1);
        i_req[l]     = 1'b1;
    endtask

    task automatic refill(input int done);
        if (done >= 0) begin
            i_req[done] = 1'b0;
            if ($urandom_range(0, 2) == 0) load_lane(done);
        end
        for (int l = 0; l < NL; l++) begin
            if (!i_req[l] && l != done && $urandom_range(0, 2) == 0) load_lane(l);
        end
        if (i_req == '0) load_lane(int'($urandom_range(0, NL - 1)));
    endtask

    // Called at a negedge with requests stable; runs one predicted transfer to completion.
    task automatic run_xfer(input bit allow_abort, input int reset_at, output bit timed_out);
        int                   lane;
        int                   abort_at;
        int                   wait_cyc;
        logic [NUM_LANES-1:0] onehot;
        timed_out = 1'b0;
        lane = rr_pick(model_ptr, i_req);
        if (lane < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL no_request: req=0x%0h, want a requesting lane", i_req);
            timed_out = 1'b1;
            return;
        end
        model_ptr = lane;
        onehot = '0;
        onehot[lane] = 1'b1;
        wait_cyc = 0;
        while (o_grant == '0 && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (o_grant == '0) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_timeout: grant=0x0 after %0d cycles, want 0x%0h", wait_cyc, onehot);
            timed_out = 1'b1;
            return;
        end
        chk("grant_lane", 32'(o_grant), 32'(onehot));
        abort_at = (allow_abort && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, NBITS - 1)) : -1;
        if (abort_at < 0 && reset_at < 0) begin
            exp_q.push_back('{lane: LANE_W'(lane), word: lane_word[lane], perr: lane_perr[lane]});
            last_word = lane_word[lane];
        end
        for (int k = 0; k < NBITS; k++) begin
            chk("grant_hold", 32'(o_grant), 32'(onehot));
            chk("bit_en", 32'(o_bit_en), 32'd1);
            if (k == abort_at) begin
                i_req[lane] = 1'b0;
                @(negedge clk);
                exp_aborts++;
                chk("abort_pulse", 32'(o_abort), 32'd1);
                chk("abort_grant", 32'(o_grant), 32'd0);
                chk("abort_no_valid", 32'(o_word_valid), 32'd0);
                chk("abort_keeps_word", 32'(o_word_out), 32'(last_word));
                refill(lane);
                return;
            end
            if (k == reset_at) begin
                @(posedge clk);
                #1 i_reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk_reset_outputs("mid_shift_reset");
                @(posedge clk);
                #1 i_reset = 1'b0;
                model_ptr = NL - 1;
                last_word = '0;
                @(negedge clk);
                return;
            end
            i_ser_in       = NUM_LANES'($urandom);
            i_ser_in[lane] = stream_bit(lane_word[lane], lane_perr[lane], k);
            @(negedge clk);
        end
        chk("valid_latency", 32'(o_word_valid), 32'd1);
        refill(lane);
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d words still pending, want 0", exp_q.size());
        end
    endtask

    // Consumer back-pressure: mostly random, with occasional 5-cycle stalls.
    initial begin : ready_gen
        i_word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 15) == 0) begin
                i_word_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
            end else begin
                i_word_ready = ($urandom_range(0, 9) < 6);
            end
        end
    end

    // Monitor: every presented word must match the head of the expectation queue.
    initial begin : monitor
        exp_t hd;
        bit   hs_pending;
        int   since_hs;
        hs_pending = 1'b0;
        since_hs   = 0;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                hs_pending = 1'b0;
                continue;
            end
            if (o_abort) seen_aborts++;
            if (hs_pending) begin
                since_hs++;
                if (since_hs == 1) begin
                    chk("idle_after_handshake", 32'({o_busy, o_grant}), 32'd0);
                end else begin
                    if (req_s != '0) chk("grant_one_cycle_after_hs", 32'(o_grant != '0), 32'd1);
                    hs_pending = 1'b0;
                end
            end
            if (o_word_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: word=0x%0h lane=%0d, want no word",
                             o_word_out, o_word_lane);
                end else begin
                    hd = exp_q[0];
                    chk("word_out", 32'(o_word_out), 32'(hd.word));
                    chk("word_lane", 32'(o_word_lane), 32'(hd.lane));
                    chk("parity_err", 32'(o_parity_err), 32'(hd.perr));
                    chk("grant_during_out", 32'(o_grant), 32'd0);
                    chk("busy_during_out", 32'(o_busy), 32'd1);
                    if (i_word_ready) begin
                        void'(exp_q.pop_front());
                        hs_pending = 1'b1;
                        since_hs   = 0;
                    end
                end
            end else begin
                chk("parity_err_idle", 32'(o_parity_err), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit to;
        to = 1'b0;
        i_reset  = 1'b1;
        i_req    = '0;
        i_ser_in = '0;
        last_word = '0;
        for (int l = 0; l < NL; l++) begin
            lane_word[l] = '0;
            lane_perr[l] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 i_reset = 1'b0;
        model_ptr = NL - 1;
        @(negedge clk);
        chk_reset_outputs("idle_no_req");

        // Directed opener: lane 1 alone, stream 1,0,1,1,0,0,1,0 (0x4D LSB first).
        lane_word[1] = 8'h4D;
        lane_perr[1] = 1'b0;
        i_req[1]     = 1'b1;
        for (int t = 0; t < NUM_XFERS && !to; t++) begin
            run_xfer(t != 0, -1, to);
        end
        i_req = '0;
        drain();

        // Mid-SHIFT reset with every lane requesting, then pointer restarts at lane 0.
        if (!to) begin
            for (int l = 0; l < NL; l++) load_lane(l);
            run_xfer(1'b0, 3, to);
        end
        if (!to) begin
            for (int l = 0; l < NL; l++) load_lane(l);
            run_xfer(1'b0, -1, to);
            i_req = '0;
            drain();
        end
        repeat (3) @(negedge clk);
        chk("abort_cycles", 32'(seen_aborts), 32'(exp_aborts));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
